modulo_mux_display: RTL and testbench

- Time-multiplexes the single shared 7-segment bus (seg) between the left and right displays (an[0]=left, an[1]=right).
- Decodes each 4-bit digit to hex and inserts a blanking interval between slots to suppress ghosting.
- Accepts new digit pairs (data word / syndrome from the SECDED decoder) through a valid/ready handshake into a one-deep shadow buffer.
- Commits buffered pairs only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/modulo_mux_display.sv | 191 +++++++++++++++++++
 tb/tb_modulo_mux_display.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/modulo_mux_display.sv
// Two-digit 7-segment multiplexer: blank/show slots per display, with a one-deep
// shadow buffer that is committed to the active digits only at frame end.
module modulo_mux_display #(
    parameter int T_SHOW  = 50000,
    parameter int T_BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig_izq,
    input  logic [3:0] dig_der,
    input  logic [1:0] apagar_in,
    input  logic       valido,
    output logic       listo,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       fin_trama
);

    localparam int T_MAX = (T_SHOW > T_BLANK) ? T_SHOW : T_BLANK;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] LIM_SHOW  = CW'(T_SHOW - 1);
    localparam logic [CW-1:0] LIM_BLANK = CW'(T_BLANK - 1);
    localparam logic [6:0]    SEG_OFF   = 7'b1111111;

    typedef enum logic [1:0] {
        B_IZQ = 2'd0,
        S_IZQ = 2'd1,
        B_DER = 2'd2,
        S_DER = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;
    logic          w_fin;
    logic          w_commit;

    logic [3:0] r_act_izq, r_act_der, r_sh_izq, r_sh_der;
    logic [1:0] r_act_apg, r_sh_apg;
    logic [3:0] w_act_izq_nxt, w_act_der_nxt;
    logic [1:0] w_act_apg_nxt;
    logic       r_listo;

    logic [1:0] r_an, w_an_nxt;
    logic [6:0] r_seg, w_seg_nxt;
    logic       r_fin, w_fin_nxt;

    // Active-low hex decode, bit order g..a.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Slot sequencing: next state and slot counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        case (r_state)
            B_IZQ, B_DER: w_last = (r_cnt == LIM_BLANK);
            S_IZQ, S_DER: w_last = (r_cnt == LIM_SHOW);
            default:      w_last = 1'b1;
        endcase
        if (w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
                B_IZQ:   w_state_nxt = S_IZQ;
                S_IZQ:   w_state_nxt = B_DER;
                B_DER:   w_state_nxt = S_DER;
                S_DER:   w_state_nxt = B_IZQ;
                default: w_state_nxt = B_IZQ;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign w_fin    = (r_state == S_DER) && w_last;
    assign w_commit = w_fin && !r_listo;

    // Values the active registers will hold next cycle (commit has priority over load).
    always_comb begin
        if (w_commit) begin
            w_act_izq_nxt = r_sh_izq;
            w_act_der_nxt = r_sh_der;
            w_act_apg_nxt = r_sh_apg;
        end else begin
            w_act_izq_nxt = r_act_izq;
            w_act_der_nxt = r_act_der;
            w_act_apg_nxt = r_act_apg;
        end
    end

    // Output decode of next-cycle state so the pins come straight from flops.
    always_comb begin
        w_an_nxt  = 2'b11;
        w_seg_nxt = SEG_OFF;
        w_fin_nxt = (w_state_nxt == S_DER) && (w_cnt_nxt == LIM_SHOW);
        case (w_state_nxt)
            S_IZQ: begin
                w_an_nxt  = 2'b10;
                w_seg_nxt = w_act_apg_nxt[0] ? SEG_OFF : hex7(w_act_izq_nxt);
            end
            S_DER: begin
                w_an_nxt  = 2'b01;
                w_seg_nxt = w_act_apg_nxt[1] ? SEG_OFF : hex7(w_act_der_nxt);
            end
            default: begin
                w_an_nxt  = 2'b11;
                w_seg_nxt = SEG_OFF;
            end
        endcase
    end

    // State and slot counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= B_IZQ;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow buffer load and frame-boundary commit; r_listo doubles as the empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_listo   <= 1'b1;
            r_sh_izq  <= 4'h0;
            r_sh_der  <= 4'h0;
            r_sh_apg  <= 2'b00;
            r_act_izq <= 4'h0;
            r_act_der <= 4'h0;
            r_act_apg <= 2'b11;
        end else begin
            r_act_izq <= w_act_izq_nxt;
            r_act_der <= w_act_der_nxt;
            r_act_apg <= w_act_apg_nxt;
            if (w_commit) begin
                r_listo <= 1'b1;
            end else if (valido && r_listo) begin
                r_sh_izq <= dig_izq;
                r_sh_der <= dig_der;
                r_sh_apg <= apagar_in;
                r_listo  <= 1'b0;
            end else begin
                r_listo <= r_listo;
            end
        end
    end

    // Display output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 2'b11;
            r_seg <= SEG_OFF;
            r_fin <= 1'b0;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_fin <= w_fin_nxt;
        end
    end

    assign listo     = r_listo;
    assign an        = r_an;
    assign seg       = r_seg;
    assign fin_trama = r_fin;

endmodule

// File: tb/tb_modulo_mux_display.sv
// Bench for modulo_mux_display with T_BLANK=2, T_SHOW=4 (12-cycle frame); expected
// slot contents are queued as stimulus is issued and checked by a separate monitor.
module tb_modulo_mux_display;

    localparam int FR = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig_izq = 4'h0;
    logic [3:0] dig_der = 4'h0;
    logic [1:0] apagar_in = 2'b00;
    logic       valido = 1'b0;
    logic       listo;
    logic [6:0] seg;
    logic [1:0] an;
    logic       fin_trama;

    modulo_mux_display #(.T_SHOW(4), .T_BLANK(2)) dut (
        .clk(clk), .rst(rst), .dig_izq(dig_izq), .dig_der(dig_der),
        .apagar_in(apagar_in), .valido(valido), .listo(listo),
        .seg(seg), .an(an), .fin_trama(fin_trama)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int base = 0;
    int fbase = 1000000;
    int n_tests = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc - base, act, expv);
        end
    endtask

    task automatic push_pair(input logic [6:0] l, input logic [6:0] r);
        exp_q.push_back({2'b10, l});
        exp_q.push_back({2'b01, r});
    endtask

    task automatic goto(input int r);
        while (cyc - base < r) @(negedge clk);
    endtask

    // Monitor: checks fin_trama timing, blank cycles and every shown slot.
    logic [1:0] prev_an = 2'b11;
    logic [8:0] cur = 9'h1ff;
    int         rf;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            rf = cyc - fbase;
            chk("fin_trama", int'(fin_trama), (rf >= 0 && (rf % FR) == FR - 1) ? 1 : 0);
            if (an != 2'b11) begin
                if (prev_an != an) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL slot_underflow at cycle %0d: got an=%b, expected no slot", cyc - base, an);
                        cur = 9'h1ff;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("slot_an", int'(an), int'(cur[8:7]));
                chk("slot_seg", int'(seg), int'(cur[6:0]));
            end else begin
                chk("blank_seg", int'(seg), 32'h7f);
            end
            prev_an = an;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        push_pair(7'b1111111, 7'b1111111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        base  = cyc;
        fbase = cyc;
        chk("listo_reset", int'(listo), 1);

        goto(3);
        chk("listo_c3", int'(listo), 1);
        valido = 1'b1; dig_izq = 4'h5; dig_der = 4'hA; apagar_in = 2'b00;
        push_pair(7'b0010010, 7'b0001000);

        goto(4);
        valido = 1'b0; dig_izq = 4'hF; dig_der = 4'hF; apagar_in = 2'b11;
        chk("listo_c4", int'(listo), 0);

        goto(5);
        valido = 1'b1; dig_izq = 4'h3; dig_der = 4'hC; apagar_in = 2'b00;
        push_pair(7'b0110000, 7'b1000110);
        push_pair(7'b0110000, 7'b1000110);
        acc = -1;
        for (int k = 0; k < 30; k++) begin
            if (listo) begin
                acc = cyc - base;
                break;
            end
            @(negedge clk);
        end
        chk("accept_cycle", acc, 12);
        @(negedge clk);
        valido = 1'b0; dig_izq = 4'h8; dig_der = 4'h8;
        chk("listo_c13", int'(listo), 0);

        goto(23);
        chk("listo_c23", int'(listo), 0);
        goto(24);
        chk("listo_c24", int'(listo), 1);

        goto(35);
        chk("listo_c35", int'(listo), 1);
        valido = 1'b1; dig_izq = 4'h7; dig_der = 4'h7; apagar_in = 2'b10;
        push_pair(7'b1111000, 7'b1111111);

        goto(36);
        valido = 1'b0; apagar_in = 2'b00;
        chk("listo_c36", int'(listo), 0);
        goto(47);
        chk("listo_c47", int'(listo), 0);
        goto(48);
        chk("listo_c48", int'(listo), 1);

        goto(50);
        valido = 1'b1; dig_izq = 4'h1; dig_der = 4'h2; apagar_in = 2'b00;
        goto(51);
        valido = 1'b0;
        chk("listo_c51", int'(listo), 0);

        goto(57);
        rst   = 1'b1;
        fbase = cyc + 1;
        push_pair(7'b1111111, 7'b1111111);
        push_pair(7'b1111111, 7'b1111111);

        goto(58);
        rst = 1'b0;
        chk("listo_after_rst", int'(listo), 1);
        chk("an_after_rst", int'(an), 3);

        goto(70);
        chk("listo_c70", int'(listo), 1);
        goto(83);
        chk("listo_c83", int'(listo), 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
